// File: rtl/vga_pkg.sv
// Shared types and rules for the VGA pixel shifter.
// Word width default, repeat encoding and refill threshold live here.
package vga_pkg;

    localparam int WORD_W_DEF = 32;

    // Clocks per pixel minus one: 0..3 -> 1..4 clocks.
    typedef logic [1:0] rep_cfg_t;

    function automatic logic refill_needed(
        input int unsigned level,
        input int unsigned depth
    );
        return level <= depth / 2;
    endfunction

endpackage

// File: rtl/vga_pixel_shifter_if.sv
// CPU-side pixel word push handshake.
// The master drives words, the shifter answers with wr_ready.
interface vga_pixel_shifter_if
    import vga_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
);
    logic              wr_valid;
    logic [WORD_W-1:0] wr_data;
    logic              wr_ready;

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/vga_word_fifo.sv
// Small word FIFO feeding the pixel shifter.
// Flush wins over push and pop.
module vga_word_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic [AW:0]  level,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    logic do_push, do_pop;

    assign full    = level_q == (AW+1)'(DEPTH);
    assign empty   = level_q == '0;
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_d = level_q + 1'b1;
            end else if (do_pop && !do_push) begin
                level_d = level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end
endmodule

// File: rtl/vga_pixel_shifter.sv
// 1bpp VGA pixel shifter with word FIFO, pixel repeat and underflow flag.
// Bit 0 of each word is shown first; reload on the last bit is gapless.
module vga_pixel_shifter
    import vga_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    parameter  int WORD_W     = WORD_W_DEF,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1,
    localparam int BW         = $clog2(WORD_W)
) (
    input  logic     clk,
    input  logic     rst_n,
    vga_pixel_shifter_if.slave wr,
    input  logic     pixel_en,
    input  logic     frame_start,
    input  rep_cfg_t repeat_cfg,
    input  logic     clr_underflow,
    output logic     pixel,
    output logic [LW-1:0] fifo_level,
    output logic     refill_req,
    output logic     underflow
);
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);

    logic [WORD_W-1:0] sh_q, sh_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    rep_cfg_t rep_cnt_q, rep_cnt_d;
    rep_cfg_t rep_cfg_q, rep_cfg_d;
    logic sh_valid_q, sh_valid_d;
    logic pixel_q, pixel_d;
    logic underflow_q, underflow_d;
    logic uf_set, consume, step, last;
    rep_cfg_t eff_cfg;
    logic fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [WORD_W-1:0] fifo_rdata;

    assign wr.wr_ready = !fifo_full && !frame_start;
    assign fifo_push   = wr.wr_valid && wr.wr_ready;
    assign refill_req  = refill_needed(32'(fifo_level), 32'(FIFO_DEPTH));
    assign pixel       = pixel_q;
    assign underflow   = underflow_q;

    // A new repeat setting only takes effect at the start of a pixel.
    assign eff_cfg   = (rep_cnt_q == '0) ? repeat_cfg : rep_cfg_q;
    assign rep_cfg_d = eff_cfg;
    assign consume   = pixel_en && sh_valid_q;
    assign step      = consume && (rep_cnt_q == eff_cfg);
    assign last      = step && (bit_cnt_q == LAST_BIT);

    always_comb begin
        sh_d        = sh_q;
        bit_cnt_d   = bit_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        sh_valid_d  = sh_valid_q;
        pixel_d     = 1'b0;
        uf_set      = 1'b0;
        fifo_pop    = 1'b0;
        if (frame_start) begin
            sh_valid_d = 1'b0;
            bit_cnt_d  = '0;
            rep_cnt_d  = '0;
        end else begin
            if (consume) begin
                pixel_d = sh_q[0];
                if (step) begin
                    sh_d      = sh_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + 2'd1;
                end
            end
            uf_set = pixel_en && !sh_valid_q;
            if (last && fifo_empty) begin
                sh_valid_d = 1'b0;
            end
            if (!fifo_empty && (!sh_valid_q || last)) begin
                fifo_pop   = 1'b1;
                sh_d       = fifo_rdata;
                bit_cnt_d  = '0;
                rep_cnt_d  = '0;
                sh_valid_d = 1'b1;
            end
        end
        underflow_d = clr_underflow ? 1'b0 : (underflow_q || uf_set);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q        <= '0;
            bit_cnt_q   <= '0;
            rep_cnt_q   <= '0;
            rep_cfg_q   <= '0;
            sh_valid_q  <= 1'b0;
            pixel_q     <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sh_q        <= sh_d;
            bit_cnt_q   <= bit_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_cfg_q   <= rep_cfg_d;
            sh_valid_q  <= sh_valid_d;
            pixel_q     <= pixel_d;
            underflow_q <= underflow_d;
        end
    end

    vga_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (frame_start),
        .wdata (wr.wr_data),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
endmodule

// File: tb/tb_vga_pixel_shifter.sv
// Directed bench for vga_pixel_shifter: vector table plus corner sequences.
// Pixels are sampled 1 time unit after each rising edge.
module tb_vga_pixel_shifter;
    import vga_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pixel_en = 1'b0;
    logic frame_start = 1'b0;
    rep_cfg_t repeat_cfg = '0;
    logic clr_underflow = 1'b0;
    logic pixel;
    logic [2:0] fifo_level;
    logic refill_req;
    logic underflow;

    int errors = 0;
    int checks = 0;

    vga_pixel_shifter_if #(.WORD_W(32)) wr_if ();

    vga_pixel_shifter #(
        .FIFO_DEPTH (4),
        .WORD_W     (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr            (wr_if),
        .pixel_en      (pixel_en),
        .frame_start   (frame_start),
        .repeat_cfg    (repeat_cfg),
        .clr_underflow (clr_underflow),
        .pixel         (pixel),
        .fifo_level    (fifo_level),
        .refill_req    (refill_req),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [31:0]  w0;
        logic [31:0]  w1;
        int           nwords;
        rep_cfg_t     cfg;
        int           nclk;
        logic [127:0] exp;
        logic         exp_uf;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = w;
        step();
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pixel_en = 1'b0;
        frame_start = 1'b0;
        clr_underflow = 1'b0;
        repeat_cfg = '0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data = '0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic run_vec(input vec_t v);
        logic [127:0] got;
        do_reset();
        repeat_cfg = v.cfg;
        push(v.w0);
        if (v.nwords > 1) push(v.w1);
        step();
        got = '0;
        pixel_en = 1'b1;
        for (int i = 0; i < v.nclk; i++) begin
            step();
            got[i] = pixel;
        end
        pixel_en = 1'b0;
        check({v.name, "_pix"}, got, v.exp);
        check({v.name, "_uf"}, 128'(underflow), 128'(v.exp_uf));
    endtask

    initial begin
        logic [127:0] got;

        vecs[0] = '{"w5", 32'h0000_0005, 32'h0, 1, 2'd0, 32,
                    128'h5, 1'b0};
        vecs[1] = '{"ones_zeros", 32'hFFFF_FFFF, 32'h0, 2, 2'd0, 64,
                    128'h0000_0000_FFFF_FFFF, 1'b0};
        vecs[2] = '{"rep4", 32'h0000_0001, 32'h0, 1, 2'd3, 128,
                    128'hF, 1'b0};
        vecs[3] = '{"rep2", 32'hA5A5_0F0F, 32'h0, 1, 2'd1, 64,
                    128'hCC33_CC33_00FF_00FF, 1'b0};
        vecs[4] = '{"two_words", 32'hDEAD_BEEF, 32'h1234_5678, 2, 2'd0, 64,
                    128'h1234_5678_DEAD_BEEF, 1'b0};

        wr_if.wr_valid = 1'b0;
        wr_if.wr_data = '0;
        step();
        check("rst_pixel", 128'(pixel), 128'(0));
        check("rst_uf", 128'(underflow), 128'(0));
        check("rst_level", 128'(fifo_level), 128'(0));
        check("rst_ready", 128'(wr_if.wr_ready), 128'(1));
        check("rst_refill", 128'(refill_req), 128'(1));

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // Fill: first word goes straight to the shifter.
        do_reset();
        push(32'h1111_1111);
        check("fill_l1", 128'(fifo_level), 128'(1));
        push(32'h2222_2222);
        check("push_pop_same", 128'(fifo_level), 128'(1));
        push(32'h3333_3333);
        push(32'h4444_4444);
        push(32'h5555_5555);
        check("full_level", 128'(fifo_level), 128'(4));
        check("full_ready", 128'(wr_if.wr_ready), 128'(0));
        check("full_refill", 128'(refill_req), 128'(0));
        push(32'h6666_6666);
        check("refused_push", 128'(fifo_level), 128'(4));
        pixel_en = 1'b1;
        repeat (31) step();
        check("pop_not_yet", 128'(fifo_level), 128'(4));
        step();
        check("pop1_level", 128'(fifo_level), 128'(3));
        check("pop1_refill", 128'(refill_req), 128'(0));
        repeat (32) step();
        check("pop2_level", 128'(fifo_level), 128'(2));
        check("pop2_refill", 128'(refill_req), 128'(1));
        pixel_en = 1'b0;
        wr_if.wr_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("midrst_level", 128'(fifo_level), 128'(0));
        check("midrst_pixel", 128'(pixel), 128'(0));
        wr_if.wr_valid = 1'b0;

        do_reset();
        pixel_en = 1'b1;
        step();
        check("uf_set", 128'(underflow), 128'(1));
        check("uf_pixel", 128'(pixel), 128'(0));
        clr_underflow = 1'b1;
        step();
        check("uf_clr_prio", 128'(underflow), 128'(0));
        clr_underflow = 1'b0;
        step();
        check("uf_reset", 128'(underflow), 128'(1));
        pixel_en = 1'b0;
        step();
        check("uf_sticky", 128'(underflow), 128'(1));

        do_reset();
        push(32'h0000_0001);
        push(32'h0000_0002);
        push(32'h0000_0003);
        push(32'h0000_0004);
        check("fs_pre_level", 128'(fifo_level), 128'(3));
        frame_start = 1'b1;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data = 32'hFFFF_FFFF;
        #1;
        check("fs_ready", 128'(wr_if.wr_ready), 128'(0));
        step();
        frame_start = 1'b0;
        wr_if.wr_valid = 1'b0;
        check("fs_level", 128'(fifo_level), 128'(0));
        pixel_en = 1'b1;
        step();
        check("fs_shvalid_uf", 128'(underflow), 128'(1));
        check("fs_discard", 128'(fifo_level), 128'(0));
        pixel_en = 1'b0;

        // Repeat change mid-pixel finishes the current pixel at 4 clocks.
        do_reset();
        repeat_cfg = 2'd3;
        push(32'h0000_0005);
        step();
        got = '0;
        pixel_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            got[i] = pixel;
            if (i == 1) repeat_cfg = 2'd0;
        end
        pixel_en = 1'b0;
        check("rep_change", got, 128'h2F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
